// File: rtl/dcache_wt_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Define DCACHE_STATS_EN to add the saturating stat_hits / stat_misses load counters.
module dcache_wt_ctrl #(
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        d_mem_req,
  output logic        d_mem_wr,
  output logic [31:0] d_mem_addr,
  output logic [31:0] d_mem_data_out,
  input  logic [31:0] d_mem_data_in,
  input  logic        d_mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);

  localparam int unsigned OB    = $clog2(LINE_WORDS);
  localparam int unsigned IB    = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 32 - IB - OB - 2;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RD_RESP   = 3'd1;
  localparam logic [2:0] S_FILL_REQ  = 3'd2;
  localparam logic [2:0] S_FILL_ACK  = 3'd3;
  localparam logic [2:0] S_FILL_DATA = 3'd4;
  localparam logic [2:0] S_WR_REQ    = 3'd5;
  localparam logic [2:0] S_WR_ACK    = 3'd6;
  localparam logic [2:0] S_WR_DATA   = 3'd7;

  logic [2:0]           state_q, state_d;
  logic [31:2]          addr_q, addr_d;
  logic [OB-1:0]        w_q, w_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic                 cpu_done_q, cpu_done_d;
  logic [31:0]          cpu_rdata_q, cpu_rdata_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_wr_q, mem_wr_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;

  logic [31:0]      data_q [NUM_LINES][LINE_WORDS];
  logic [TAG_W-1:0] tag_q  [NUM_LINES];

  logic             data_we;
  logic [IB-1:0]    data_widx;
  logic [OB-1:0]    data_woff;
  logic [31:0]      data_wval;
  logic             tag_we;

  // Incoming request fields, decoded straight from the CPU port
  logic [OB-1:0]    req_off;
  logic [IB-1:0]    req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             req_hit;
  logic             accept;

  // Latched request fields used for the remainder of the access
  logic [OB-1:0]    lat_off;
  logic [IB-1:0]    lat_idx;
  logic [TAG_W-1:0] lat_tag;
  logic             lat_hit;

  logic             unused_addr_bits;

  assign req_off = cpu_addr[OB+1:2];
  assign req_idx = cpu_addr[IB+OB+1:OB+2];
  assign req_tag = cpu_addr[31:IB+OB+2];
  assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign lat_off = addr_q[OB+1:2];
  assign lat_idx = addr_q[IB+OB+1:OB+2];
  assign lat_tag = addr_q[31:IB+OB+2];
  assign lat_hit = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);

  assign unused_addr_bits = ^cpu_addr[1:0];

  // A done pulse is still visible while back in IDLE after a store, so hold off
  // accepting the same (still asserted) request in that cycle.
  assign accept = (state_q == S_IDLE) && cpu_req && !cpu_done_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    w_d         = w_q;
    valid_d     = valid_q;
    cpu_done_d  = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mem_req_d   = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    data_we     = 1'b0;
    data_widx   = lat_idx;
    data_woff   = w_q;
    data_wval   = d_mem_data_in;
    tag_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d = cpu_addr[31:2];
          if (cpu_wr) begin
            state_d = S_WR_REQ;
          end else if (req_hit) begin
            state_d     = S_RD_RESP;
            cpu_done_d  = 1'b1;
            cpu_rdata_d = data_q[req_idx][req_off];
          end else begin
            state_d          = S_FILL_REQ;
            w_d              = '0;
            valid_d[req_idx] = 1'b0;
          end
        end
      end

      S_RD_RESP: state_d = S_IDLE;

      S_FILL_REQ: begin
        if (d_mem_ready) begin
          mem_req_d  = 1'b1;
          mem_wr_d   = 1'b0;
          mem_addr_d = {lat_tag, lat_idx, w_q, 2'b00};
          state_d    = S_FILL_ACK;
        end
      end

      S_FILL_ACK: begin
        if (!d_mem_ready) state_d = S_FILL_DATA;
      end

      S_FILL_DATA: begin
        if (d_mem_ready) begin
          data_we = 1'b1;
          if (w_q == OB'(LINE_WORDS - 1)) begin
            tag_we           = 1'b1;
            valid_d[lat_idx] = 1'b1;
            cpu_done_d       = 1'b1;
            // The last word lands in the array on this edge, so bypass it
            cpu_rdata_d      = (lat_off == w_q) ? d_mem_data_in : data_q[lat_idx][lat_off];
            w_d              = '0;
            state_d          = S_RD_RESP;
          end else begin
            w_d     = w_q + OB'(1);
            state_d = S_FILL_REQ;
          end
        end
      end

      S_WR_REQ: begin
        if (d_mem_ready) begin
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b1;
          mem_addr_d  = {addr_q, 2'b00};
          mem_wdata_d = cpu_wdata;
          state_d     = S_WR_ACK;
        end
      end

      S_WR_ACK: begin
        if (!d_mem_ready) state_d = S_WR_DATA;
      end

      S_WR_DATA: begin
        if (d_mem_ready) begin
          cpu_done_d = 1'b1;
          state_d    = S_IDLE;
          if (lat_hit) begin
            data_we   = 1'b1;
            data_woff = lat_off;
            data_wval = cpu_wdata;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      w_q         <= '0;
      valid_q     <= '0;
      cpu_done_q  <= 1'b0;
      cpu_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      w_q         <= w_d;
      valid_q     <= valid_d;
      cpu_done_q  <= cpu_done_d;
      cpu_rdata_q <= cpu_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Data and tag storage carry no reset; validity lives in valid_q
  always_ff @(posedge clk) begin
    if (data_we) data_q[data_widx][data_woff] <= data_wval;
    if (tag_we)  tag_q[lat_idx] <= lat_tag;
  end

  assign cpu_done       = cpu_done_q;
  assign cpu_rdata      = cpu_rdata_q;
  assign d_mem_req      = mem_req_q;
  assign d_mem_wr       = mem_wr_q;
  assign d_mem_addr     = mem_addr_q;
  assign d_mem_data_out = mem_wdata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hits_q;
  logic [31:0] misses_q;

  // Load hit/miss counters, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if (accept && !cpu_wr) begin
      if (req_hit) begin
        if (hits_q != '1) hits_q <= hits_q + 32'd1;
      end else begin
        if (misses_q != '1) misses_q <= misses_q + 32'd1;
      end
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_dcache_wt_ctrl.sv
// Self-checking bench for dcache_wt_ctrl: latency-4 memory model, line-level cache
// reference model, directed scenarios followed by randomized loads/stores.
module tb_dcache_wt_ctrl;

  localparam int unsigned NL = 16;
  localparam int unsigned LW = 4;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        d_mem_req;
  logic        d_mem_wr;
  logic [31:0] d_mem_addr;
  logic [31:0] d_mem_data_out;
  logic [31:0] d_mem_data_in;
  logic        d_mem_ready;
`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dcache_wt_ctrl #(.NUM_LINES(NL), .LINE_WORDS(LW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_req        (cpu_req),
    .cpu_wr         (cpu_wr),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_done       (cpu_done),
    .d_mem_req      (d_mem_req),
    .d_mem_wr       (d_mem_wr),
    .d_mem_addr     (d_mem_addr),
    .d_mem_data_out (d_mem_data_out),
    .d_mem_data_in  (d_mem_data_in),
    .d_mem_ready    (d_mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hits      (stat_hits),
    .stat_misses    (stat_misses)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model (word-indexed, latency 4) ----------------
  logic [31:0] phys [int unsigned];
  logic        rdy_q;
  logic        hold = 1'b0;
  logic        busy;
  int          cnt;
  txn_t        cur;
  txn_t        got_q [$];

  assign d_mem_ready = rdy_q && !hold;

  function automatic logic [31:0] phys_rd(input logic [31:0] wi);
    if (phys.exists(wi)) return phys[wi];
    return wi;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q         <= 1'b1;
      busy          <= 1'b0;
      cnt           <= 0;
      d_mem_data_in <= '0;
    end else if (busy) begin
      check("mem_addr_stable", d_mem_addr, cur.addr);
      check("mem_wr_stable", d_mem_wr, cur.wr);
      if (cur.wr) check("mem_wdata_stable", d_mem_data_out, cur.data);
      if (cnt == 1) begin
        busy  <= 1'b0;
        rdy_q <= 1'b1;
        if (cur.wr) phys[cur.addr >> 2] = cur.data;
        else d_mem_data_in <= phys_rd(cur.addr >> 2);
      end
      cnt <= cnt - 1;
    end else if (d_mem_req && d_mem_ready) begin
      cur = '{d_mem_wr, d_mem_addr, d_mem_data_out};
      got_q.push_back(cur);
      busy  <= 1'b1;
      rdy_q <= 1'b0;
      cnt   <= 4;
    end
  end

  // ---------------- per-cycle output monitor ----------------
  logic txn_active = 1'b0;
  logic prev_req = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_cpu_done", cpu_done, 0);
      check("rst_cpu_rdata", cpu_rdata, 0);
      check("rst_mem_req", d_mem_req, 0);
      check("rst_mem_wr", d_mem_wr, 0);
      check("rst_mem_addr", d_mem_addr, 0);
      check("rst_mem_data_out", d_mem_data_out, 0);
`ifdef DCACHE_STATS_EN
      check("rst_stat_hits", stat_hits, 0);
      check("rst_stat_misses", stat_misses, 0);
`endif
    end else begin
      if (d_mem_req) begin
        check("req_when_ready", d_mem_ready, 1);
        check("req_single_pulse", prev_req, 0);
      end
      if (hold) check("req_while_busy", d_mem_req, 0);
      if (cpu_done) check("done_only_when_pending", txn_active, 1);
    end
    prev_req = d_mem_req;
  end

  // ---------------- reference cache model ----------------
  bit          m_valid [NL];
  logic [31:0] m_tag   [NL];
  logic [31:0] m_data  [NL][LW];
  logic [31:0] ref_mem [int unsigned];
  int          m_hits = 0;
  int          m_misses = 0;

  function automatic logic [31:0] ref_rd(input logic [31:0] wi);
    if (ref_mem.exists(wi)) return ref_mem[wi];
    return wi;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_valid[i] = 0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int cycles);
    txn_t        exp_q [$];
    logic [31:0] wi;
    int          off, idx;
    logic [31:0] tag;
    bit          hit;
    wi  = addr >> 2;
    off = int'(wi % LW);
    idx = int'((wi / LW) % NL);
    tag = wi / (LW * NL);
    hit = m_valid[idx] && (m_tag[idx] == tag);
    if (wr) exp_q.push_back('{1'b1, wi << 2, wdata});
    else if (!hit)
      for (int w = 0; w < LW; w++) exp_q.push_back('{1'b0, (wi - 32'(off) + 32'(w)) << 2, 32'd0});
    got_q.delete();

    cpu_req    = 1'b1;
    cpu_wr     = wr;
    cpu_addr   = addr;
    cpu_wdata  = wdata;
    txn_active = 1'b1;
    cycles     = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!cpu_done && cycles < 400);
    check("done_seen", cpu_done, 1);
    rdata = cpu_rdata;

    if (wr) begin
      ref_mem[wi] = wdata;
      if (hit) m_data[idx][off] = wdata;
    end else begin
      if (hit) m_hits++;
      else begin
        m_misses++;
        for (int w = 0; w < LW; w++) m_data[idx][w] = ref_rd(wi - 32'(off) + 32'(w));
        m_valid[idx] = 1;
        m_tag[idx]   = tag;
      end
      check("load_data", cpu_rdata, m_data[idx][off]);
      if (hit) check("hit_latency", 32'(cycles), 32'd2);
    end

    @(posedge clk);
    #1;
    cpu_req    = 1'b0;
    txn_active = 1'b0;

    check("mem_txn_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check("mem_txn_addr", got_q[i].addr, exp_q[i].addr);
      check("mem_txn_wr", got_q[i].wr, exp_q[i].wr);
      if (exp_q[i].wr) check("mem_txn_wdata", got_q[i].data, exp_q[i].data);
    end
`ifdef DCACHE_STATS_EN
    check("stat_hits", stat_hits, 32'(m_hits));
    check("stat_misses", stat_misses, 32'(m_misses));
`endif
  endtask

  task automatic init_mem();
    phys[0] = 32'd3;  phys[1] = 32'd1;  phys[2] = 32'h5555aaaa;  phys[3] = 32'd2;
    ref_mem[0] = 32'd3; ref_mem[1] = 32'd1; ref_mem[2] = 32'h5555aaaa; ref_mem[3] = 32'd2;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  int          cyc;
  int          h;
  int          guard;
  logic        rwr;
  logic [31:0] raddr;

  initial begin
    init_mem();
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Cold load: whole line 0x0..0xC fetched in order
    do_access(1'b0, 32'h8, 32'h0, rd, cyc);
    check("cold_load_rdata", rd, 32'h5555aaaa);
    check("cold_load_ntxn", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < got_q.size(); i++) check("cold_load_addr", got_q[i].addr, 32'(i * 4));
`ifdef DCACHE_STATS_EN
    check("cold_load_misses", stat_misses, 32'd1);
`endif

    // Hit in the freshly filled line
    do_access(1'b0, 32'hC, 32'h0, rd, cyc);
    check("hit_rdata", rd, 32'd2);
    check("hit_ntxn", 32'(got_q.size()), 32'd0);
    check("hit_cycles", 32'(cyc), 32'd2);
`ifdef DCACHE_STATS_EN
    check("hit_count", stat_hits, 32'd1);
`endif

    // Store hit, then load back from the cache
    do_access(1'b1, 32'h4, 32'hDEADBEEF, rd, cyc);
    check("st_hit_ntxn", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("st_hit_addr", got_q[0].addr, 32'h4);
    do_access(1'b0, 32'h4, 32'h0, rd, cyc);
    check("st_hit_readback", rd, 32'hDEADBEEF);
    check("st_hit_readback_ntxn", 32'(got_q.size()), 32'd0);

    // Store miss: no allocate; later load fills and evicts index 0
    do_access(1'b1, 32'h100, 32'h12345678, rd, cyc);
    check("st_miss_ntxn", 32'(got_q.size()), 32'd1);
    do_access(1'b0, 32'h100, 32'h0, rd, cyc);
    check("st_miss_load_rdata", rd, 32'h12345678);
    check("st_miss_load_ntxn", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) check("st_miss_load_last", got_q[3].addr, 32'h10C);
    do_access(1'b0, 32'h0, 32'h0, rd, cyc);
    check("evicted_reload_rdata", rd, 32'd3);
    check("evicted_reload_ntxn", 32'(got_q.size()), 32'd4);

    // Memory busy for 10 cycles before a fill request
    hold = 1'b1;
    fork
      do_access(1'b0, 32'h40, 32'h0, rd, cyc);
      begin
        repeat (10) @(posedge clk);
        #1 hold = 1'b0;
      end
    join
    check("held_fill_rdata", rd, 32'h10);
    check("held_fill_ntxn", 32'(got_q.size()), 32'd4);

    // Reset while the third word of a fill is outstanding
    got_q.delete();
    cpu_req    = 1'b1;
    cpu_wr     = 1'b0;
    cpu_addr   = 32'h208;
    txn_active = 1'b1;
    guard      = 0;
    while (got_q.size() < 3 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("midfill_third_req_seen", 32'(got_q.size()), 32'd3);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    cpu_req    = 1'b0;
    txn_active = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    do_access(1'b0, 32'h208, 32'h0, rd, cyc);
    check("refetch_rdata", rd, 32'h82);
    check("refetch_ntxn", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < got_q.size(); i++) check("refetch_addr", got_q[i].addr, 32'h200 + 32'(i * 4));

    // Randomized loads and stores over a handful of tags
    for (int n = 0; n < 300; n++) begin
      h     = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 6)) : 0;
      rwr   = ($urandom_range(0, 2) == 0);
      raddr = 32'($urandom_range(0, 1023)) & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) raddr = raddr | 32'hF000_0000;
      if (h > 0) begin
        hold = 1'b1;
        fork
          do_access(rwr, raddr, $urandom, rd, cyc);
          begin
            repeat (h) @(posedge clk);
            #1 hold = 1'b0;
          end
        join
      end else begin
        do_access(rwr, raddr, $urandom, rd, cyc);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
